// File: rtl/pulse_train_sequencer.sv
`timescale 1ns / 1ps
// pulse_train_sequencer: accepts a burst command (count, gap) and drives the
// downstream pulse generator with one start strobe per pulse, tracking each
// high/low excursion of the generator output until the burst completes, is
// aborted, or the generator stops responding.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ready for a command
// WAIT_READY | waiting (untimed) for the generator to report ready
// FIRE       | one cycle; start strobe is registered out of this state
// WAIT_HIGH  | waiting for gen_pulse to rise, timed
// WAIT_LOW   | waiting for gen_pulse to fall, timed
// GAP        | idle spacing before the next pulse
// DONE       | one cycle; done strobe is registered out of this state
module pulse_train_sequencer #(
    parameter int COUNT_W        = 8,
    parameter int GAP_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic               abort,
    input  logic               gen_ready,
    input  logic               gen_pulse,
    output logic               start,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pulses_sent,
    output logic               error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The load cycle itself is not a decrement, so the terminal count is hit
    // after exactly TIMEOUT_CYCLES cycles in the timed state.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        FIRE,
        WAIT_HIGH,
        WAIT_LOW,
        GAP,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COUNT_W-1:0] count_q;
    logic [GAP_W-1:0]   gap_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [COUNT_W-1:0] ps_next;
    logic               tmo_tc;
    logic               gap_tc;
    logic               accept;
    logic               tmo_load;
    logic               gap_load;
    logic               ps_inc;
    logic               err_set;

    assign ps_next   = pulses_sent + COUNT_W'(1);
    assign tmo_tc    = (tmo_cnt == '0);
    assign gap_tc    = (gap_cnt == '0);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; losing gen_ready outranks abort so the
    // error is never masked, and a falling pulse is counted before abort acts.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo_load  = 1'b0;
        gap_load  = 1'b0;
        ps_inc    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_count == '0) ? DONE : WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (gen_ready) begin
                    tmo_load  = 1'b1;
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                state_nxt = abort ? DONE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!gen_ready) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (!gen_pulse && tmo_tc) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (abort) begin
                    state_nxt = DONE;
                end else if (gen_pulse) begin
                    tmo_load  = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!gen_pulse) begin
                    ps_inc = 1'b1;
                end
                if (!gen_ready) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (!gen_pulse) begin
                    if (ps_next == count_q || abort) begin
                        state_nxt = DONE;
                    end else if (gap_q == '0) begin
                        state_nxt = WAIT_READY;
                    end else begin
                        gap_load  = 1'b1;
                        state_nxt = GAP;
                    end
                end else if (tmo_tc) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (abort) begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (!gen_ready) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (abort) begin
                    state_nxt = DONE;
                end else if (gap_tc) begin
                    state_nxt = WAIT_READY;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, pulse counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            gap_q       <= '0;
            pulses_sent <= '0;
            error       <= 1'b0;
        end else if (accept) begin
            count_q     <= cmd_count;
            gap_q       <= cmd_gap;
            pulses_sent <= '0;
            error       <= 1'b0;
        end else begin
            if (ps_inc) begin
                pulses_sent <= ps_next;
            end
            if (err_set) begin
                error <= 1'b1;
            end
        end
    end

    // Edge timeout and gap down-counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (tmo_load) begin
                tmo_cnt <= TMO_LOAD;
            end else if ((state == WAIT_HIGH || state == WAIT_LOW) && !tmo_tc) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
            if (gap_load) begin
                gap_cnt <= gap_q - GAP_W'(1);
            end else if (state == GAP && !gap_tc) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Registered one-cycle strobes out of FIRE and DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start <= 1'b0;
            done  <= 1'b0;
        end else begin
            start <= (state == FIRE);
            done  <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
`timescale 1ns / 1ps
// Bench for pulse_train_sequencer: a small generator model answers each start,
// a burst-level timing model predicts start/done edges, pulse falls and the
// error edge from the sequencer's timing rules, and one negedge process
// compares every output on every cycle against that prediction.
module tb_pulse_train_sequencer;

    localparam int TMO     = 16;
    localparam int GEN_DLY = 3;
    localparam int GEN_W   = 5;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_count;
    logic [15:0] cmd_gap;
    logic       abort;
    logic       gen_ready;
    logic       gen_pulse;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] pulses_sent;
    logic       error;

    pulse_train_sequencer #(
        .COUNT_W(8),
        .GAP_W(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_count(cmd_count),
        .cmd_gap(cmd_gap),
        .abort(abort),
        .gen_ready(gen_ready),
        .gen_pulse(gen_pulse),
        .start(start),
        .busy(busy),
        .done(done),
        .pulses_sent(pulses_sent),
        .error(error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // burst prediction
    int acc_edge  = 32'h3fff_ffff;
    int done_edge = -1;
    int err_edge  = -1;
    int prev_ps   = 0;
    bit prev_err  = 0;
    int exp_starts[$];
    int exp_falls[$];

    // observations for the literal checks
    int obs_start[$];
    int obs_done[$];
    int err_at_acc = -1;
    bit start_d    = 0;
    int last_ab    = -1;
    int last_g     = -1;

    bit gen_stall = 0;
    int gen_age   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_start_at(input int c);
        foreach (exp_starts[i]) if (exp_starts[i] == c) return 1;
        return 0;
    endfunction

    function automatic int exp_ps_at(input int c);
        int n = 0;
        if (c < acc_edge) return prev_ps;
        foreach (exp_falls[i]) if (exp_falls[i] <= c) n++;
        return n;
    endfunction

    function automatic int exp_err_at(input int c);
        if (c < acc_edge) return int'(prev_err);
        return (err_edge >= 0 && c >= err_edge) ? 1 : 0;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: gen_pulse is sampled high on edges S+3..S+7 after a
    // start that rose at edge S, and low again from edge S+8.
    always @(posedge clk) begin
        #1;
        if (!reset || gen_stall) begin
            gen_age   = 0;
            gen_pulse = 1'b0;
        end else begin
            if (start) gen_age = 1;
            else if (gen_age != 0 && gen_age < 1000) gen_age = gen_age + 1;
            gen_pulse = (gen_age >= GEN_DLY && gen_age < GEN_DLY + GEN_W);
        end
    end

    // Per-cycle comparison against the burst model, plus observation capture.
    always @(negedge clk) begin
        if (start && !start_d) obs_start.push_back(cyc);
        if (done) obs_done.push_back(cyc);
        if (cyc == acc_edge) err_at_acc = int'(error);
        start_d = start;
        chk("start", int'(start), exp_start_at(cyc));
        chk("done", int'(done), (cyc == done_edge) ? 1 : 0);
        chk("busy", int'(busy), (cyc >= acc_edge && cyc < done_edge) ? 1 : 0);
        chk("cmd_ready", int'(cmd_ready), (cyc >= acc_edge && cyc < done_edge) ? 0 : 1);
        chk("pulses_sent", int'(pulses_sent), exp_ps_at(cyc));
        chk("error", int'(error), exp_err_at(cyc));
    end

    // Issue one command and run it to completion. rdy_dly>0 holds gen_ready
    // low until it is first sampled high rdy_dly edges after acceptance.
    // ab_pulse selects the pulse whose WAIT_LOW gets aborted (0 = none).
    task automatic run_cmd(input int cnt, input int gap, input int rdy_dly,
                           input bit stall, input int ab_pulse, input bit ab_fall);
        int k;
        int s;
        int f;
        int g;
        int ab;
        int end_c;
        @(posedge clk);
        #1;
        k        = cyc;
        prev_ps  = exp_falls.size();
        prev_err = (err_edge >= 0);
        exp_starts.delete();
        exp_falls.delete();
        obs_start.delete();
        obs_done.delete();
        err_edge = -1;
        ab       = -1;
        g        = -1;
        acc_edge = k + 1;
        if (cnt == 0) begin
            done_edge = acc_edge + 1;
        end else begin
            g = acc_edge + ((rdy_dly == 0) ? 1 : rdy_dly);
            s = g + 1;
            for (int i = 1; i <= cnt; i++) begin
                exp_starts.push_back(s);
                if (stall) begin
                    err_edge  = s + TMO;
                    done_edge = s + TMO + 1;
                    break;
                end
                f = s + GEN_DLY + GEN_W;
                if (i == ab_pulse) begin
                    ab = ab_fall ? f : s + GEN_DLY + 2;
                    if (ab_fall) exp_falls.push_back(f);
                    done_edge = ab + 1;
                    break;
                end
                exp_falls.push_back(f);
                if (i == cnt) done_edge = f + 1;
                else s = f + gap + 2;
            end
        end
        gen_stall = stall;
        gen_ready = (rdy_dly == 0);
        cmd_count = 8'(cnt);
        cmd_gap   = 16'(gap);
        cmd_valid = 1'b1;
        end_c     = done_edge + 12;
        while (cyc < end_c) begin
            @(posedge clk);
            #1;
            if (cyc == acc_edge) cmd_valid = 1'b0;
            if (rdy_dly != 0 && cyc == g - 1) gen_ready = 1'b1;
            abort = (ab >= 0 && cyc == ab - 1);
        end
        abort   = 1'b0;
        last_ab = ab;
        last_g  = g;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        cmd_gap   = '0;
        abort     = 1'b0;
        gen_ready = 1'b1;
        gen_pulse = 1'b0;
        #2;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_no_start", obs_start.size(), 0);

        // three pulses, gap 4: spacing 3 + 5 + 4 + 2
        run_cmd(3, 4, 0, 0, 0, 0);
        chk("b3_starts", obs_start.size(), 3);
        if (obs_start.size() == 3) begin
            chk("b3_first_lat", obs_start[0] - acc_edge, 2);
            chk("b3_space1", obs_start[1] - obs_start[0], 14);
            chk("b3_space2", obs_start[2] - obs_start[1], 14);
        end
        chk("b3_ps", int'(pulses_sent), 3);
        chk("b3_dones", obs_done.size(), 1);
        chk("b3_err", int'(error), 0);

        // zero-length burst
        run_cmd(0, 7, 0, 0, 0, 0);
        chk("b0_starts", obs_start.size(), 0);
        chk("b0_dones", obs_done.size(), 1);
        if (obs_done.size() == 1) chk("b0_done_lat", obs_done[0] - acc_edge, 1);
        chk("b0_ps", int'(pulses_sent), 0);

        // generator not ready at accept, ready sampled 20 edges later
        run_cmd(1, 0, 20, 0, 0, 0);
        chk("rdy_starts", obs_start.size(), 1);
        if (obs_start.size() == 1) chk("rdy_start_lat", obs_start[0] - last_g, 1);
        chk("rdy_ps", int'(pulses_sent), 1);

        // stalled generator: timeout in WAIT_HIGH
        run_cmd(2, 1, 0, 1, 0, 0);
        if (obs_start.size() == 1 && obs_done.size() == 1)
            chk("tmo_done_lat", obs_done[0] - obs_start[0], 17);
        else
            chk("tmo_obs_count", obs_start.size() * 10 + obs_done.size(), 11);
        chk("tmo_err", int'(error), 1);
        chk("tmo_ps", int'(pulses_sent), 0);

        // gap 0 burst; error must clear on accept
        run_cmd(2, 0, 0, 0, 0, 0);
        chk("clr_err_at_acc", err_at_acc, 0);
        if (obs_start.size() == 2) chk("g0_space", obs_start[1] - obs_start[0], 10);
        else chk("g0_starts", obs_start.size(), 2);
        chk("g0_ps", int'(pulses_sent), 2);

        // abort in the middle of the 2nd pulse's WAIT_LOW
        run_cmd(5, 2, 0, 0, 2, 0);
        if (obs_done.size() == 1) chk("ab_done_lat", obs_done[0] - last_ab, 1);
        else chk("ab_dones", obs_done.size(), 1);
        chk("ab_ps", int'(pulses_sent), 1);
        chk("ab_err", int'(error), 0);

        // abort on the 2nd pulse's falling sample: that pulse still counts
        run_cmd(5, 2, 0, 0, 2, 1);
        chk("abf_ps", int'(pulses_sent), 2);
        chk("abf_err", int'(error), 0);

        // full-scale count
        run_cmd(255, 0, 0, 0, 0, 0);
        chk("max_ps", int'(pulses_sent), 255);
        chk("max_starts", obs_start.size(), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
